// File: rtl/ta_arb_pkg.sv
// Shared types and constants for the timing-adapter drain arbiter.
package ta_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_e;

  localparam int ERR_BIT = 10;
  localparam int EOP_BIT = 9;
  localparam int SOP_BIT = 8;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

// File: rtl/ta_arb_age_ctr.sv
// Per-channel saturating wait-age counter and start-eligibility compare.
// One cycle from a waiting beat to an updated age; elig_o is combinational.
module ta_arb_age_ctr #(
  parameter int START_LEVEL = 16,
  parameter int AGE_LIMIT   = 255,
  parameter int AGE_WIDTH   = 8,
  parameter int FILL_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic [FILL_WIDTH-1:0] fill_level_i,
  input  logic                  clr_i,
  output logic                  elig_o
);

  logic [AGE_WIDTH-1:0] age_q, age_d;

  // Age only counts while a beat is actually waiting and the channel is not being served.
  always_comb begin
    age_d = age_q;
    if (!valid_i || clr_i) begin
      age_d = '0;
    end else if (age_q != '1) begin
      age_d = age_q + AGE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign elig_o = valid_i &&
                  ((int'(fill_level_i) >= START_LEVEL) || (int'(age_q) >= AGE_LIMIT));

endmodule

// File: rtl/ta_fifo_drain_arbiter.sv
// Packet-granular arbiter draining two timing-adapter FIFOs onto one Avalon-ST stream.
// Zero-latency pass-through while granted; out_ready feeds straight back to the granted FIFO.
module ta_fifo_drain_arbiter
  import ta_arb_pkg::*;
#(
  parameter int START_LEVEL = 16,
  parameter int AGE_LIMIT   = 255,
  parameter int AGE_WIDTH   = 8,
  parameter int MAX_BEATS   = 1518,
  parameter int BEAT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            a_fill_level,
  input  logic                  a_valid,
  input  logic [BEAT_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic [6:0]            b_fill_level,
  input  logic                  b_valid,
  input  logic [BEAT_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  out_valid,
  output logic [BEAT_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  out_chan,
  output logic                  sop_err,
  output logic                  abort,
  output logic [15:0]           pkt_cnt_a,
  output logic [15:0]           pkt_cnt_b
);

  localparam int BCW = $clog2(MAX_BEATS + 1);

  arb_state_e     state_q, state_d;
  logic           rr_last_q, rr_last_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic           sop_err_q, sop_err_d;
  logic           abort_q, abort_d;
  logic [15:0]    pkt_cnt_a_q, pkt_cnt_a_d;
  logic [15:0]    pkt_cnt_b_q, pkt_cnt_b_d;

  logic elig_a, elig_b;
  logic clr_a, clr_b;

  // A channel's age is frozen at zero from the grant decision until it is released.
  assign clr_a = (state_q == GRANT_A) || (state_d == GRANT_A);
  assign clr_b = (state_q == GRANT_B) || (state_d == GRANT_B);

  ta_arb_age_ctr #(
    .START_LEVEL (START_LEVEL),
    .AGE_LIMIT   (AGE_LIMIT),
    .AGE_WIDTH   (AGE_WIDTH),
    .FILL_WIDTH  (7)
  ) u_age_a (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (a_valid),
    .fill_level_i (a_fill_level),
    .clr_i        (clr_a),
    .elig_o       (elig_a)
  );

  ta_arb_age_ctr #(
    .START_LEVEL (START_LEVEL),
    .AGE_LIMIT   (AGE_LIMIT),
    .AGE_WIDTH   (AGE_WIDTH),
    .FILL_WIDTH  (7)
  ) u_age_b (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (b_valid),
    .fill_level_i (b_fill_level),
    .clr_i        (clr_b),
    .elig_o       (elig_b)
  );

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    beat_cnt_d  = beat_cnt_q;
    sop_err_d   = 1'b0;
    abort_d     = 1'b0;
    pkt_cnt_a_d = pkt_cnt_a_q;
    pkt_cnt_b_d = pkt_cnt_b_q;
    out_valid   = 1'b0;
    out_data    = '0;
    out_chan    = CH_A;
    a_ready     = 1'b0;
    b_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the channel served less recently wins.
        if (elig_a && (!elig_b || rr_last_q == CH_B)) begin
          state_d    = GRANT_A;
          rr_last_d  = CH_A;
          beat_cnt_d = '0;
        end else if (elig_b) begin
          state_d    = GRANT_B;
          rr_last_d  = CH_B;
          beat_cnt_d = '0;
        end
      end

      GRANT_A, GRANT_B: begin
        out_chan  = (state_q == GRANT_B) ? CH_B : CH_A;
        out_valid = out_chan ? b_valid : a_valid;
        out_data  = out_chan ? b_data : a_data;
        a_ready   = (state_q == GRANT_A) && out_ready;
        b_ready   = (state_q == GRANT_B) && out_ready;

        if (out_valid && out_ready) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
          sop_err_d  = (beat_cnt_q == '0) && !out_data[SOP_BIT];
          // eop wins over the watchdog when both land on the same beat.
          if (out_data[EOP_BIT]) begin
            state_d = IDLE;
            if (out_chan == CH_B) begin
              pkt_cnt_b_d = pkt_cnt_b_q + 16'd1;
            end else begin
              pkt_cnt_a_d = pkt_cnt_a_q + 16'd1;
            end
          end else if (beat_cnt_d == BCW'(MAX_BEATS)) begin
            state_d = IDLE;
            abort_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_last_q   <= CH_B;
      beat_cnt_q  <= '0;
      sop_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      pkt_cnt_a_q <= '0;
      pkt_cnt_b_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      beat_cnt_q  <= beat_cnt_d;
      sop_err_q   <= sop_err_d;
      abort_q     <= abort_d;
      pkt_cnt_a_q <= pkt_cnt_a_d;
      pkt_cnt_b_q <= pkt_cnt_b_d;
    end
  end

  assign sop_err   = sop_err_q;
  assign abort     = abort_q;
  assign pkt_cnt_a = pkt_cnt_a_q;
  assign pkt_cnt_b = pkt_cnt_b_q;

endmodule

// File: tb/tb_ta_fifo_drain_arbiter.sv
// Bench for ta_fifo_drain_arbiter: queue-backed FIFOs feed the DUT and a
// cycle-level reference of the grant rules predicts every output.
module tb_ta_fifo_drain_arbiter;

  localparam int START_LEVEL = 16;
  localparam int AGE_LIMIT   = 255;
  localparam int AGE_MAX     = 255;
  localparam int MAXB        = 8;
  localparam int SOP         = 8;
  localparam int EOP         = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  a_fill_level = '0, b_fill_level = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [10:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic        out_valid, out_chan, sop_err, abort;
  logic        out_ready = 1'b1;
  logic [10:0] out_data;
  logic [15:0] pkt_cnt_a, pkt_cnt_b;

  wire [16:0] obs = {out_valid, out_chan, out_data, a_ready, b_ready, sop_err, abort};

  ta_fifo_drain_arbiter #(.MAX_BEATS(MAXB)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_fill_level (a_fill_level),
    .a_valid      (a_valid),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_fill_level (b_fill_level),
    .b_valid      (b_valid),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .out_chan     (out_chan),
    .sop_err      (sop_err),
    .abort        (abort),
    .pkt_cnt_a    (pkt_cnt_a),
    .pkt_cnt_b    (pkt_cnt_b)
  );

  always #5 clk = ~clk;

  logic [10:0] qa[$];
  logic [10:0] qb[$];
  int pad_a, pad_b;
  int errors, checks;

  // Reference: owner -1 = nobody, 0 = A, 1 = B.
  int   m_owner, m_last, m_beats, m_xfer;
  int   m_age[2];
  int   m_pkt[2];
  logic m_sop_err, m_abort;

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_beats = 0; m_xfer = -1;
    m_age[0] = 0; m_age[1] = 0; m_pkt[0] = 0; m_pkt[1] = 0;
    m_sop_err = 1'b0; m_abort = 1'b0;
  endtask

  task automatic model_step();
    logic v[2];
    logic [10:0] d[2];
    int f[2];
    logic el[2];
    int pick;
    v[0] = a_valid; v[1] = b_valid;
    d[0] = a_data;  d[1] = b_data;
    f[0] = int'(a_fill_level); f[1] = int'(b_fill_level);
    m_sop_err = 1'b0; m_abort = 1'b0; m_xfer = -1;
    if (m_owner < 0) begin
      for (int c = 0; c < 2; c++) el[c] = v[c] && (f[c] >= START_LEVEL || m_age[c] >= AGE_LIMIT);
      if (el[0] && el[1]) pick = 1 - m_last;
      else if (el[0])     pick = 0;
      else if (el[1])     pick = 1;
      else                pick = -1;
      for (int c = 0; c < 2; c++)
        m_age[c] = (!v[c] || c == pick) ? 0 : ((m_age[c] < AGE_MAX) ? m_age[c] + 1 : AGE_MAX);
      if (pick >= 0) begin
        m_owner = pick; m_last = pick; m_beats = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++)
        m_age[c] = (!v[c] || c == m_owner) ? 0 : ((m_age[c] < AGE_MAX) ? m_age[c] + 1 : AGE_MAX);
      if (v[m_owner] && out_ready) begin
        m_xfer = m_owner;
        if (m_beats == 0 && !d[m_owner][SOP]) m_sop_err = 1'b1;
        m_beats++;
        if (d[m_owner][EOP]) begin
          m_pkt[m_owner] = (m_pkt[m_owner] + 1) % 65536;
          m_owner = -1;
        end else if (m_beats == MAXB) begin
          m_abort = 1'b1;
          m_owner = -1;
        end
      end
    end
  endtask

  function automatic logic [16:0] exp_vec();
    logic ov, oc, ar, br;
    logic [10:0] od;
    ov = 1'b0; oc = 1'b0; ar = 1'b0; br = 1'b0; od = '0;
    if (m_owner == 0) begin
      ov = a_valid; od = a_data; ar = out_ready;
    end else if (m_owner == 1) begin
      ov = b_valid; od = b_data; oc = 1'b1; br = out_ready;
    end
    return {ov, oc, od, ar, br, m_sop_err, m_abort};
  endfunction

  function automatic logic [6:0] fill_of(int sz, int pad);
    int f;
    f = (sz == 0) ? 0 : sz + pad;
    if (f > 64) f = 64;
    return 7'(f);
  endfunction

  task automatic drive_inputs();
    a_valid = (qa.size() != 0);
    a_data  = a_valid ? qa[0] : 11'd0;
    a_fill_level = fill_of(qa.size(), pad_a);
    b_valid = (qb.size() != 0);
    b_data  = b_valid ? qb[0] : 11'd0;
    b_fill_level = fill_of(qb.size(), pad_b);
  endtask

  task automatic push_beats(input int ch, input int n, input bit sop_first, input bit eop_last);
    for (int i = 0; i < n; i++) begin
      logic [10:0] b;
      b = {1'b0, (eop_last && i == n - 1), (sop_first && i == 0), 8'($urandom)};
      if (ch == 0) qa.push_back(b);
      else         qb.push_back(b);
    end
  endtask

  task automatic tick();
    logic [10:0] junk;
    @(posedge clk);
    model_step();
    #1;
    if (m_xfer == 0)      junk = qa.pop_front();
    else if (m_xfer == 1) junk = qb.pop_front();
    drive_inputs();
    #1;
  endtask

  task automatic do_reset();
    qa.delete(); qb.delete();
    pad_a = 0; pad_b = 0; out_ready = 1'b1;
    drive_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    qa.delete(); qb.delete();
    pad_a = 0; pad_b = 0; out_ready = 1'b1;
    reset = 1'b1;
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (obs !== 17'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required %h", obs, 17'd0);
    end
    checks++;
    if ({pkt_cnt_a, pkt_cnt_b} !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got %h required 0", {pkt_cnt_a, pkt_cnt_b});
    end
    pad_a = 20;
    push_beats(0, 4, 1'b1, 1'b1);
    drive_inputs();
    #1;
    checks++;
    if ({out_valid, a_ready, b_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_hold: got %b required 000", {out_valid, a_ready, b_ready});
    end
    qa.delete();
    drive_inputs();
    reset = 1'b0;
    #1;
    tick();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_idle: got %h required %h", obs, exp_vec());
    end
  endtask

  task automatic test_single_packet();
    int ar_cycles;
    do_reset();
    pad_a = 16;
    push_beats(0, 4, 1'b1, 1'b1);
    drive_inputs();
    #1;
    ar_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL single_cycle%0d: got %h required %h", i, obs, exp_vec());
      end
      if (a_ready) ar_cycles++;
      tick();
    end
    checks++;
    if (ar_cycles != 4) begin
      errors++; $display("FAIL single_ready_cycles: got %0d required 4", ar_cycles);
    end
    checks++;
    if (pkt_cnt_a !== 16'd1 || pkt_cnt_b !== 16'd0) begin
      errors++; $display("FAIL single_pkt_cnt: got a=%0d b=%0d required a=1 b=0", pkt_cnt_a, pkt_cnt_b);
    end
  endtask

  task automatic test_alternation();
    int seq[$];
    int exp_seq[$];
    bit same;
    do_reset();
    pad_a = 30; pad_b = 30;
    for (int p = 0; p < 3; p++) begin
      push_beats(0, 3, 1'b1, 1'b1);
      push_beats(1, 3, 1'b1, 1'b1);
    end
    drive_inputs();
    #1;
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL alt_cycle%0d: got %h required %h", i, obs, exp_vec());
      end
      if (out_valid && out_ready) seq.push_back(int'(out_chan));
      tick();
    end
    for (int p = 0; p < 6; p++)
      for (int k = 0; k < 3; k++) exp_seq.push_back(p % 2);
    same = (seq.size() == exp_seq.size());
    for (int i = 0; i < seq.size() && same; i++) if (seq[i] != exp_seq[i]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++; $display("FAIL alt_order: got %0d beats %p required %p", seq.size(), seq, exp_seq);
    end
    checks++;
    if (pkt_cnt_a !== 16'd3 || pkt_cnt_b !== 16'd3) begin
      errors++; $display("FAIL alt_pkt_cnt: got a=%0d b=%0d required 3 3", pkt_cnt_a, pkt_cnt_b);
    end
  endtask

  task automatic test_age();
    int n;
    do_reset();
    pad_b = 0;
    push_beats(1, 2, 1'b1, 1'b1);
    drive_inputs();
    #1;
    n = 0;
    while (!b_ready && n < 400) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL age_wait%0d: got %h required %h", n, obs, exp_vec());
      end
      tick();
      n++;
    end
    checks++;
    if (n != AGE_LIMIT + 1) begin
      errors++; $display("FAIL age_grant_cycle: got %0d required %0d", n, AGE_LIMIT + 1);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL age_drain%0d: got %h required %h", i, obs, exp_vec());
      end
      tick();
    end
    checks++;
    if (pkt_cnt_b !== 16'd1) begin
      errors++; $display("FAIL age_pkt_cnt: got %0d required 1", pkt_cnt_b);
    end
  endtask

  task automatic test_hold();
    int seq[$];
    do_reset();
    pad_a = 20;
    push_beats(0, 3, 1'b1, 1'b0);
    drive_inputs();
    #1;
    repeat (4) tick();
    pad_b = 30;
    push_beats(1, 3, 1'b1, 1'b1);
    drive_inputs();
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, a_ready, b_ready, out_chan} !== 4'b0100) begin
        errors++; $display("FAIL hold_gap%0d: got %b required 0100", i, {out_valid, a_ready, b_ready, out_chan});
      end
      tick();
    end
    push_beats(0, 3, 1'b0, 1'b1);
    drive_inputs();
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL hold_resume%0d: got %h required %h", i, obs, exp_vec());
      end
      if (out_valid && out_ready) seq.push_back(int'(out_chan));
      tick();
    end
    checks++;
    if (seq.size() != 6 || seq[0] != 0 || seq[2] != 0 || seq[3] != 1 || seq[5] != 1) begin
      errors++; $display("FAIL hold_order: got %p required A A A B B B", seq);
    end
    checks++;
    if (pkt_cnt_a !== 16'd1 || pkt_cnt_b !== 16'd1 || sop_err !== 1'b0) begin
      errors++; $display("FAIL hold_pkt_cnt: got a=%0d b=%0d required 1 1", pkt_cnt_a, pkt_cnt_b);
    end
  endtask

  task automatic test_watchdog();
    int seq[$];
    int exp_seq[$];
    int n_abort, n_sop_err;
    bit same;
    do_reset();
    pad_a = 20; pad_b = 30;
    push_beats(0, 12, 1'b1, 1'b1);
    push_beats(1, 3, 1'b1, 1'b1);
    drive_inputs();
    #1;
    n_abort = 0; n_sop_err = 0;
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL wd_cycle%0d: got %h required %h", i, obs, exp_vec());
      end
      if (abort === 1'b1) n_abort++;
      if (sop_err === 1'b1) n_sop_err++;
      if (out_valid && out_ready) seq.push_back(int'(out_chan));
      tick();
    end
    for (int i = 0; i < 8; i++) exp_seq.push_back(0);
    for (int i = 0; i < 3; i++) exp_seq.push_back(1);
    for (int i = 0; i < 4; i++) exp_seq.push_back(0);
    same = (seq.size() == exp_seq.size());
    for (int i = 0; i < seq.size() && same; i++) if (seq[i] != exp_seq[i]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++; $display("FAIL wd_order: got %p required %p", seq, exp_seq);
    end
    checks++;
    if (n_abort != 1 || n_sop_err != 1) begin
      errors++; $display("FAIL wd_pulses: got abort=%0d sop_err=%0d required 1 1", n_abort, n_sop_err);
    end
    checks++;
    if (pkt_cnt_a !== 16'd1 || pkt_cnt_b !== 16'd1) begin
      errors++; $display("FAIL wd_pkt_cnt: got a=%0d b=%0d required 1 1", pkt_cnt_a, pkt_cnt_b);
    end
  endtask

  task automatic test_reset_midpkt();
    do_reset();
    pad_a = 20;
    push_beats(0, 6, 1'b1, 1'b1);
    drive_inputs();
    #1;
    repeat (3) tick();
    out_ready = 1'b0;
    drive_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec() || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall%0d: got %h required %h", i, obs, exp_vec());
      end
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({out_valid, a_ready, b_ready} !== 3'b000) begin
      errors++; $display("FAIL midpkt_async: got %b required 000", {out_valid, a_ready, b_ready});
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, a_ready, b_ready} !== 3'b000) begin
      errors++; $display("FAIL midpkt_ready_in_reset: got %b required 000", {out_valid, a_ready, b_ready});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 17'd0) begin
      errors++; $display("FAIL midpkt_idle: got %h required %h", obs, 17'd0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL midpkt_tail%0d: got %h required %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if ($urandom_range(0, 7) == 0 && qa.size() < 40)
        push_beats(0, $urandom_range(1, 12), $urandom_range(0, 9) != 0, 1'b1);
      if ($urandom_range(0, 7) == 0 && qb.size() < 40)
        push_beats(1, $urandom_range(1, 12), $urandom_range(0, 9) != 0, 1'b1);
      if ($urandom_range(0, 31) == 0) pad_a = $urandom_range(0, 20);
      if ($urandom_range(0, 31) == 0) pad_b = $urandom_range(0, 20);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_inputs();
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL rand_cycle%0d: got %h required %h", cyc, obs, exp_vec());
      end
      checks++;
      if ({pkt_cnt_a, pkt_cnt_b} !== {16'(m_pkt[0]), 16'(m_pkt[1])}) begin
        errors++; $display("FAIL rand_pkt_cnt%0d: got a=%0d b=%0d required a=%0d b=%0d",
                           cyc, pkt_cnt_a, pkt_cnt_b, m_pkt[0], m_pkt[1]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    test_reset();
    test_single_packet();
    test_alternation();
    test_age();
    test_hold();
    test_watchdog();
    test_reset_midpkt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
